// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared width helpers for the FIFO family. Every buffer derives its
//   pointer and occupancy widths from these, so they size the same way for
//   any depth, including depths that are not a power of two.
//
//   clog2(n)       : ceiling log2, with clog2(1) = 0
//   ptr_width(d)   : bits for an index 0..d-1 (at least 1)
//   cnt_width(d)   : bits for an occupancy 0..d
package fifo_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int ptr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_param_mem.sv
// fifo_param_mem
//   WIDTH x DEPTH storage array for fifo_param. It has one synchronous write
//   port and one asynchronous read port, so the head word can be presented
//   first-word-fall-through. The cells have no reset.
//
//   clk   : write clock (rising edge)
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data, mem[raddr]
module fifo_param_mem
  import fifo_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  localparam int PW = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array is deliberately left out of reset. Resetting it would
  // turn a RAM into a bank of resettable flops, and the pointers already
  // mark every cell as invalid after reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// fifo_param
//   Synchronous circular-buffer FIFO with first-word-fall-through output,
//   occupancy count, almost-full/almost-empty thresholds and sticky
//   overflow/underflow flags. DEPTH may be any value >= 2.
//
//   clk          : rising-edge clock
//   rst          : asynchronous active-low reset (pointers, count, flags)
//   datain       : write data
//   enw          : write request
//   enr          : read request (pops the head word)
//   flush        : synchronous clear; overrides enw/enr
//   dataout      : head word (don't-care while empty)
//   full/empty   : count == DEPTH / count == 0
//   almost_full  : count >= AF_LEVEL
//   almost_empty : count <= AE_LEVEL
//   count        : current occupancy
//   overflow     : sticky, set by a rejected write
//   underflow    : sticky, set by a rejected read
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1,
  localparam int PW = ptr_width(DEPTH),
  localparam int CW = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] datain,
  input  logic             enw,
  input  logic             enr,
  input  logic             flush,
  output logic [WIDTH-1:0] dataout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          wr_acc;
  logic          rd_acc;

  // Pointers wrap explicitly at DEPTH-1, because DEPTH need not be a power
  // of two.
  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A write into a full FIFO is accepted when a read is popping the head in
  // the same cycle. A read of an empty FIFO is never accepted, even when a
  // write arrives in that cycle.
  assign wr_acc = enw & (~full | enr);
  assign rd_acc = enr & ~empty;

  // Status is decoded from the count register alone, so none of these
  // outputs has a combinational path from enw or enr.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  // NOTE: every register in this block uses non-blocking assignment. Each
  // update therefore sees the pre-edge values of count, wp and rp, whatever
  // the order of the statements.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wp <= inc_ptr(wp);
      if (rd_acc) rp <= inc_ptr(rp);

      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (enw & ~wr_acc) overflow  <= 1'b1;
      if (enr & empty)   underflow <= 1'b1;
    end
  end

  // A flush discards the write that arrives with it. The cell would be
  // unreachable anyway, but blocking it keeps the array unchanged.
  fifo_param_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc & ~flush),
    .waddr (wp),
    .wdata (datain),
    .raddr (rp),
    .rdata (dataout)
  );

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param
//   Self-checking bench for fifo_param at DEPTH=4, WIDTH=8, AF_LEVEL=3,
//   AE_LEVEL=1. A queue holds the words the FIFO should contain. Accepted
//   writes push to it, and each accepted read pops the head and compares it
//   against dataout.
module tb_fifo_param;

  localparam int DEPTH    = 4;
  localparam int WIDTH    = 8;
  localparam int AF_LEVEL = 3;
  localparam int AE_LEVEL = 1;
  localparam int CW       = 3;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] datain;
  logic             enw;
  logic             enr;
  logic             flush;
  logic [WIDTH-1:0] dataout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  fifo_param #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .datain       (datain),
    .enw          (enw),
    .enr          (enr),
    .flush        (flush),
    .dataout      (dataout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             exp_ovf = 1'b0;
  logic             exp_udf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model's occupancy and flags.
  task automatic check_state();
    int sz;
    sz = exp_q.size();
    check("count",        32'(count),        32'(sz));
    check("full",         32'(full),         32'(sz == DEPTH));
    check("empty",        32'(empty),        32'(sz == 0));
    check("almost_full",  32'(almost_full),  32'(sz >= AF_LEVEL));
    check("almost_empty", 32'(almost_empty), 32'(sz <= AE_LEVEL));
    check("overflow",     32'(overflow),     32'(exp_ovf));
    check("underflow",    32'(underflow),    32'(exp_udf));
    if (sz > 0) check("head", 32'(dataout), 32'(exp_q[0]));
  endtask

  // Drive one cycle of requests, advance the model, then check the outputs
  // 1 time unit after the edge.
  task automatic step(input logic w, input logic r, input logic f, input logic [WIDTH-1:0] d);
    int   sz;
    logic wr_ok;
    logic rd_ok;
    sz = exp_q.size();
    if (r && !f && sz > 0) check("rd_data", 32'(dataout), 32'(exp_q[0]));
    enw = w; enr = r; flush = f; datain = d;
    @(posedge clk);
    #1;
    enw = 1'b0; enr = 1'b0; flush = 1'b0;
    if (f) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      wr_ok = w && (sz < DEPTH || r);
      rd_ok = r && (sz > 0);
      if (w && !wr_ok) exp_ovf = 1'b1;
      if (r && sz == 0) exp_udf = 1'b1;
      if (rd_ok) void'(exp_q.pop_front());
      if (wr_ok) exp_q.push_back(d);
    end
    check_state();
  endtask

  initial begin
    rst = 1'b0; enw = 1'b0; enr = 1'b0; flush = 1'b0; datain = '0;
    #2;
    check_state();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Fill to full.
    step(1, 0, 0, 8'h11);
    step(1, 0, 0, 8'h22);
    step(1, 0, 0, 8'h33);
    step(1, 0, 0, 8'h44);
    // Write while full: dropped, overflow is set.
    step(1, 0, 0, 8'h55);
    // Drain: the reads return 0x11..0x44.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00);

    // Refill, then read and write 0x66 together while full.
    step(1, 0, 0, 8'h11);
    step(1, 0, 0, 8'h22);
    step(1, 0, 0, 8'h33);
    step(1, 0, 0, 8'h44);
    step(1, 1, 0, 8'h66);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00);

    // Read and write 0x77 together while empty: only the write lands.
    step(1, 1, 0, 8'h77);

    // Three words, then a flush that arrives with a write.
    step(1, 0, 0, 8'h78);
    step(1, 0, 0, 8'h79);
    step(1, 1, 1, 8'hAA);
    check("flush_empty", 32'(empty), 32'd1);

    // Reset asserted between edges at count 2.
    step(1, 0, 0, 8'h81);
    step(1, 0, 0, 8'h82);
    #3;
    rst = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    check_state();
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 0, 8'h99);
    check("after_reset", 32'(dataout), 32'h99);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 31) == 0), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
